// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around mem_arbiter.
// master: arbiter view; slave: requesters plus memory.
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        err;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      output if_gnt, if_rdata, if_valid, d_gnt, d_rdata, d_valid, err,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      input  if_gnt, if_rdata, if_valid, d_gnt, d_rdata, d_valid, err,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) single-port memory arbiter with access timeout.
// FURV_RR_EN: round-robin on contention; otherwise data port has fixed priority.
module mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic           clk,
   input logic           rst_n,
   mem_arbiter_if.master bus
);

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   logic        owner_d;
   logic        we_q;
   logic [31:0] addr_q, wdata_q;
   logic [15:0] tmo_cnt;
   logic        gnt_if, gnt_d, pick_d;
   logic        done_ok, done_tmo;
   logic        if_valid_q, d_valid_q, err_q;
   logic [31:0] if_rdata_q, d_rdata_q;

`ifdef FURV_RR_EN
   logic last_d;

   // On contention the requester not granted last wins.
   always_comb pick_d = bus.d_req && (!bus.if_req || !last_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                last_d <= 1'b1;
      else if (gnt_if || gnt_d)  last_d <= gnt_d;
   end
`else
   always_comb pick_d = bus.d_req;
`endif

   always_comb begin
      state_nxt = state;
      gnt_if    = 1'b0;
      gnt_d     = 1'b0;
      done_ok   = 1'b0;
      done_tmo  = 1'b0;
      case (state)
         IDLE: begin
            // Gate with rst_n so no grant leaks out while reset is held.
            if (rst_n && (bus.if_req || bus.d_req)) begin
               gnt_d     = pick_d;
               gnt_if    = !pick_d;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (bus.mem_ready) begin
               done_ok   = 1'b1;
               state_nxt = IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               done_tmo  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_d    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         tmo_cnt    <= '0;
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         err_q      <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if_valid_q <= (done_ok || done_tmo) && !owner_d;
         d_valid_q  <= (done_ok || done_tmo) && owner_d;
         err_q      <= done_tmo;
         if (gnt_d) begin
            owner_d <= 1'b1;
            we_q    <= bus.d_we;
            addr_q  <= bus.d_addr;
            wdata_q <= bus.d_wdata;
            tmo_cnt <= '0;
         end else if (gnt_if) begin
            owner_d <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= bus.if_addr;
            tmo_cnt <= '0;
         end else if (state == ACCESS && !bus.mem_ready) begin
            tmo_cnt <= tmo_cnt + 16'd1;
         end
         // Stores leave the requester's read data untouched; aborts return zero.
         if (done_ok && !(owner_d && we_q)) begin
            if (owner_d) d_rdata_q  <= bus.mem_rdata;
            else         if_rdata_q <= bus.mem_rdata;
         end else if (done_tmo) begin
            if (owner_d) d_rdata_q  <= '0;
            else         if_rdata_q <= '0;
         end
      end
   end

   assign bus.if_gnt    = gnt_if;
   assign bus.d_gnt     = gnt_d;
   assign bus.if_valid  = if_valid_q;
   assign bus.d_valid   = d_valid_q;
   assign bus.err       = err_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_en    = (state == ACCESS);
   assign bus.mem_we    = (state == ACCESS) && owner_d && we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT_CYCLES=4) with a completion scoreboard.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic tb_lg_d;
  logic exp_d;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && (bus.if_valid || bus.d_valid)) begin
      chk("sb_nonempty", (sb.size() > 0) === 1'b1);
      chk("sb_one_valid", (bus.if_valid & bus.d_valid) === 1'b0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_owner", bus.d_valid === e.is_d);
        chk("sb_rdata", (e.is_d ? bus.d_rdata : bus.if_rdata) === e.rdata);
        chk("sb_err", bus.err === e.err);
      end
    end
  end

  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ready = 0;
    rst_n   = 0;
    tb_lg_d = 1'b1;

    repeat (2) @(negedge clk);
    bus.if_req = 1; bus.d_req = 1; #1;
    chk("rst_if_gnt", bus.if_gnt === 1'b0);
    chk("rst_d_gnt", bus.d_gnt === 1'b0);
    chk("rst_mem_en", bus.mem_en === 1'b0);
    chk("rst_mem_we", bus.mem_we === 1'b0);
    chk("rst_valids", {bus.if_valid, bus.d_valid, bus.err} === 3'b000);
    chk("rst_rdata", {bus.if_rdata, bus.d_rdata} === 64'h0);
    chk("rst_mem_addr", bus.mem_addr === 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata === 32'h0);
    @(negedge clk);
    bus.if_req = 0; bus.d_req = 0; rst_n = 1;

    @(negedge clk);
    bus.if_req = 1; bus.if_addr = 32'h100; bus.mem_ready = 1; bus.mem_rdata = 32'h13; #1;
    chk("f_if_gnt", bus.if_gnt === 1'b1);
    chk("f_d_gnt", bus.d_gnt === 1'b0);
    chk("f_mem_en0", bus.mem_en === 1'b0);
    sb.push_back('{1'b0, 32'h13, 1'b0}); tb_lg_d = 1'b0;
    @(negedge clk);
    bus.if_req = 0; #1;
    chk("f_mem_en1", bus.mem_en === 1'b1);
    chk("f_mem_addr", bus.mem_addr === 32'h100);
    chk("f_mem_we", bus.mem_we === 1'b0);
    chk("f_no_gnt", (bus.if_gnt | bus.d_gnt) === 1'b0);
    @(negedge clk); #1;
    chk("f_if_valid", bus.if_valid === 1'b1);
    chk("f_if_rdata", bus.if_rdata === 32'h13);
    chk("f_err", bus.err === 1'b0);
    chk("f_mem_en2", bus.mem_en === 1'b0);

    @(negedge clk);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300; bus.mem_rdata = 32'hCAFEF00D; #1;
    chk("ld_gnt", bus.d_gnt === 1'b1);
    sb.push_back('{1'b1, 32'hCAFEF00D, 1'b0}); tb_lg_d = 1'b1;
    @(negedge clk);
    bus.d_req = 0; #1;
    chk("ld_mem_we", bus.mem_we === 1'b0);
    @(negedge clk);
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEADBEEF; #1;
    chk("ld_d_rdata", bus.d_rdata === 32'hCAFEF00D);
    chk("st_gnt_in_valid", (bus.d_gnt & bus.d_valid) === 1'b1);
    sb.push_back('{1'b1, 32'hCAFEF00D, 1'b0}); tb_lg_d = 1'b1;
    @(negedge clk);
    bus.d_req = 0; bus.d_we = 0; bus.mem_rdata = 32'h55555555; #1;
    chk("st_mem_we", bus.mem_we === 1'b1);
    chk("st_mem_addr", bus.mem_addr === 32'h200);
    chk("st_mem_wdata", bus.mem_wdata === 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("st_d_valid", bus.d_valid === 1'b1);
    chk("st_d_rdata_kept", bus.d_rdata === 32'hCAFEF00D);
    chk("st_mem_we_idle", bus.mem_we === 1'b0);
    chk("st_wdata_hold", bus.mem_wdata === 32'hDEADBEEF);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.if_req = 1; bus.d_req = 1; bus.d_we = 0;
      bus.if_addr = 32'h1000 + 32'(i * 4); bus.d_addr = 32'h2000 + 32'(i * 4);
      bus.mem_rdata = 32'h10000000 + 32'(i); #1;
`ifdef FURV_RR_EN
      exp_d = !tb_lg_d;
`else
      exp_d = 1'b1;
`endif
      chk("cont_d_gnt", bus.d_gnt === exp_d);
      chk("cont_if_gnt", bus.if_gnt === !exp_d);
      sb.push_back('{exp_d, 32'h10000000 + 32'(i), 1'b0}); tb_lg_d = exp_d;
      @(negedge clk); #1;
      chk("cont_no_gnt", (bus.if_gnt | bus.d_gnt) === 1'b0);
      chk("cont_mem_addr", bus.mem_addr ===
          (exp_d ? 32'h2000 + 32'(i * 4) : 32'h1000 + 32'(i * 4)));
    end
    @(negedge clk);
    bus.d_req = 0; bus.if_req = 1; bus.if_addr = 32'h1800; bus.mem_rdata = 32'h77; #1;
    chk("cont_if_after_d_drop", bus.if_gnt === 1'b1);
    sb.push_back('{1'b0, 32'h77, 1'b0}); tb_lg_d = 1'b0;
    @(negedge clk);
    bus.if_req = 0;
    @(negedge clk);

    @(negedge clk);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h400; bus.mem_ready = 0; #1;
    chk("to_gnt", bus.d_gnt === 1'b1);
    sb.push_back('{1'b1, 32'h0, 1'b1}); tb_lg_d = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.d_req = 0; #1;
      chk("to_mem_en", bus.mem_en === 1'b1);
    end
    @(negedge clk); #1;
    chk("to_mem_en_drop", bus.mem_en === 1'b0);
    chk("to_d_valid", bus.d_valid === 1'b1);
    chk("to_err", bus.err === 1'b1);
    chk("to_d_rdata", bus.d_rdata === 32'h0);

    @(negedge clk);
    bus.d_req = 1; bus.d_addr = 32'h404; bus.mem_rdata = 32'hABCD1234; #1;
    chk("tr_gnt", bus.d_gnt === 1'b1);
    sb.push_back('{1'b1, 32'hABCD1234, 1'b0}); tb_lg_d = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.d_req = 0; bus.mem_ready = (k == 3); #1;
      chk("tr_mem_en", bus.mem_en === 1'b1);
    end
    @(negedge clk);
    bus.mem_ready = 0; #1;
    chk("tr_d_valid", bus.d_valid === 1'b1);
    chk("tr_err", bus.err === 1'b0);
    chk("tr_d_rdata", bus.d_rdata === 32'hABCD1234);

    @(negedge clk);
    bus.if_req = 1; bus.if_addr = 32'h500; #1;
    chk("ra_gnt", bus.if_gnt === 1'b1);
    @(negedge clk); #1;
    chk("ra_mem_en", bus.mem_en === 1'b1);
    #2 rst_n = 0; #1;
    chk("ra_mem_en_async", bus.mem_en === 1'b0);
    chk("ra_gnt_in_rst", bus.if_gnt === 1'b0);
    @(negedge clk); #1;
    chk("ra_no_valid", (bus.if_valid | bus.d_valid) === 1'b0);
    @(negedge clk);
    rst_n = 1; bus.mem_ready = 1; bus.mem_rdata = 32'h600D; #1;
    chk("ra_regrant", bus.if_gnt === 1'b1);
    chk("ra_rdata_cleared", bus.if_rdata === 32'h0);
    sb.push_back('{1'b0, 32'h600D, 1'b0});
    @(negedge clk);
    bus.if_req = 0; #1;
    chk("ra_mem_addr", bus.mem_addr === 32'h500);
    @(negedge clk); #1;
    chk("ra_if_valid", bus.if_valid === 1'b1);
    chk("ra_if_rdata", bus.if_rdata === 32'h600D);

    repeat (3) @(negedge clk);
    #3;
    chk("sb_drained", sb.size() === 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, cycles in ACCESS without mem_ready before abort; legal range 1..65535.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 if_req  input  1  instruction-fetch request; held high until if_gnt.
REQ-005 if_addr  input  32  fetch address; sampled with if_gnt.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rdata  output  32  fetched word; valid with if_valid.
REQ-008 if_valid  output  1  one-cycle pulse; fetch complete.
REQ-009 d_req  input  1  load/store request; held high until d_gnt.
REQ-010 d_we  input  1  1 = store, 0 = load; sampled with d_gnt.
REQ-011 d_addr  input  32  data address; sampled with d_gnt.
REQ-012 d_wdata  input  32  store data; sampled with d_gnt.
REQ-013 d_gnt  output  1  data request accepted this cycle.
REQ-014 d_rdata  output  32  load word; valid with d_valid.
REQ-015 d_valid  output  1  one-cycle pulse; data access complete.
REQ-016 err  output  1  coincides with if_valid/d_valid pulse when access aborted by timeout.
REQ-017 mem_en  output  1  memory access active.
REQ-018 mem_we  output  1  memory write strobe; meaningful only with mem_en.
REQ-019 mem_addr  output  32  memory address.
REQ-020 mem_wdata  output  32  memory write data.
REQ-021 mem_rdata  input  32  memory read data; sampled with mem_ready.
REQ-022 mem_ready  input  1  memory completes current access this cycle.

Function
REQ-023 States: IDLE, ACCESS; owner register (IF/D) records granted requester.
REQ-024 IDLE: if any req high, assert exactly one gnt combinationally that cycle, latch addr/we/wdata, go ACCESS next edge; no req -> stay IDLE, gnt low.
REQ-025 Never more than one gnt high in a cycle; no gnt in ACCESS.
REQ-026 ACCESS: mem_en=1, mem_addr/mem_wdata from latched values, mem_we=latched d_we for D owner, 0 for IF owner.
REQ-027 ACCESS with mem_ready=1: capture mem_rdata into owner's rdata, pulse owner's valid next cycle with err=0, return IDLE.
REQ-028 Latency: req in IDLE at cycle N, mem_ready tied high -> gnt at N, mem_en at N+1, valid at N+2; new grant may occur in valid cycle (one access per two cycles).
REQ-029 Timeout: 16-bit counter clears on entering ACCESS, increments each ACCESS cycle without mem_ready; reaching TIMEOUT_CYCLES -> mem_en drops, owner valid and err pulse next cycle, rdata = 32'h0, return IDLE.
REQ-030 mem_ready in same cycle as timeout reached: mem_ready wins, err=0.
REQ-031 Stores: owner's rdata unchanged; d_valid still pulses.
REQ-032 rdata outputs hold last captured value between valid pulses.
REQ-033 req dropped before gnt: treated as withdrawn, no access.
REQ-034 mem_en, mem_we low in IDLE; mem_addr/mem_wdata hold latched values.

Reset
REQ-035 rst_n low: immediately state=IDLE, mem_en=0, mem_we=0, gnts/valids/err=0, counter=0, rdata/mem_addr/mem_wdata=0, last-grant=D; in-flight access dropped without valid pulse.
REQ-036 Deassertion takes effect at first clk rising edge after rst_n high.

Configuration
REQ-037 FURV_RR_EN defined: simultaneous if_req and d_req granted to requester not granted last (last-grant flag updates on every gnt; first contention after reset grants IF).
REQ-038 FURV_RR_EN undefined: fixed priority, d_req always wins; last-grant flag absent.

Verification
REQ-039 Single fetch, addr 0x100, mem_ready high, mem_rdata 0x00000013 -> if_gnt cycle 0, mem_en cycle 1, if_valid and if_rdata=0x00000013 cycle 2, err=0.
REQ-040 Store d_addr 0x200, d_wdata 0xDEADBEEF -> mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF for one cycle, d_valid pulse, d_rdata unchanged.
REQ-041 Both req held 6 accesses: with FURV_RR_EN grants IF,D,IF,D,IF,D; without it D for all until d_req drops.
REQ-042 TIMEOUT_CYCLES=4, mem_ready low -> mem_en high 4 cycles, then d_valid=1, err=1, d_rdata=0, state IDLE.
REQ-043 rst_n low mid-ACCESS -> mem_en low same cycle without clock edge, no valid pulse; after release, pending if_req granted normally.
